// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RV64 pipeline.
//   Takes the EX/MEM payload, performs LD/SD over the data bus and registers
//   the MEM/WB payload. Non-memory instructions pass through in one cycle;
//   bus accesses hold upstream off via ready until data_ok returns.
//
// Ports:
//   clk    in   1                      clock
//   reset  in   1                      synchronous, active-high reset
//   in     in   $bits(execute_data_t)  EX result, qualified by in.valid
//   ready  out  1                      1 = in accepted this cycle
//   dreq   out  $bits(dbus_req_t)      data-bus request (registered)
//   dresp  in   $bits(dbus_resp_t)     data-bus response
//   out    out  $bits(memory_data_t)   registered MEM/WB payload
//
// Build option:
//   MEM_MISALIGN_CHECK_EN - when defined, a load/store whose address is not
//   doubleword aligned skips the bus and retires as a no-op (RegWEn forced 0).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting input; ALU ops retire next edge
// REQ   | bus access outstanding; dreq held stable until data_ok

package mem_stage_pkg;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic       RegWEn;
      logic [1:0] MemRW;   // 00 none, 01 load, 10 store, 11 none
      logic [4:0] rd;
   } control_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      control_t    ctl;
      logic [63:0] alu;
      logic [63:0] rs2;
   } execute_data_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      control_t    ctl;
      logic [63:0] result;
      logic        addr31;
   } memory_data_t;

endpackage

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int         MMIO_BIT   = 31,
   parameter logic [7:0] STORE_STRB = 8'hFF
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [$bits(execute_data_t)-1:0] in,
   output logic                             ready,
   output logic [$bits(dbus_req_t)-1:0]     dreq,
   input  logic [$bits(dbus_resp_t)-1:0]    dresp,
   output logic [$bits(memory_data_t)-1:0]  out
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t        state;
   execute_data_t ex_in;
   execute_data_t ex_q;
   dbus_resp_t    rsp;
   dbus_req_t     dreq_q;
   memory_data_t  out_q;
   logic          ready_q;
   logic          is_load;
   logic          is_store;
   logic          misaligned;
   logic          unused_addr_ok;

   assign ex_in    = in;
   assign rsp      = dresp;
   assign is_load  = (ex_in.ctl.MemRW == 2'b01);
   assign is_store = (ex_in.ctl.MemRW == 2'b10);

   // Completion is keyed solely on data_ok.
   assign unused_addr_ok = rsp.addr_ok;

`ifdef MEM_MISALIGN_CHECK_EN
   assign misaligned = (ex_in.alu[2:0] != 3'b000);
`else
   assign misaligned = 1'b0;
`endif

   function automatic memory_data_t wb_payload(execute_data_t e, logic [63:0] res);
      memory_data_t m;
      m.valid  = 1'b1;
      m.pc     = e.pc;
      m.ctl    = e.ctl;
      m.result = res;
      m.addr31 = e.alu[MMIO_BIT];
      return m;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ready_q <= 1'b1;
         out_q   <= '0;
         dreq_q  <= '0;
         ex_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!ex_in.valid) begin
                  out_q.valid <= 1'b0;
               end else if (!(is_load || is_store)) begin
                  out_q <= wb_payload(ex_in, ex_in.alu);
               end else if (misaligned) begin
                  // Retire as a no-op: visible to writeback but never writes rd.
                  out_q            <= wb_payload(ex_in, ex_in.alu);
                  out_q.ctl.RegWEn <= 1'b0;
               end else begin
                  ex_q          <= ex_in;
                  out_q.valid   <= 1'b0;
                  dreq_q.valid  <= 1'b1;
                  dreq_q.addr   <= ex_in.alu;
                  dreq_q.size   <= MSIZE8;
                  dreq_q.strobe <= is_store ? STORE_STRB : 8'h00;
                  dreq_q.data   <= is_store ? ex_in.rs2 : 64'h0;
                  ready_q       <= 1'b0;
                  state         <= REQ;
               end
            end
            REQ: begin
               if (rsp.data_ok) begin
                  out_q        <= wb_payload(ex_q, (ex_q.ctl.MemRW == 2'b01) ? rsp.data : ex_q.alu);
                  dreq_q.valid <= 1'b0;
                  ready_q      <= 1'b1;
                  state        <= IDLE;
               end else begin
                  out_q.valid <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign dreq  = dreq_q;
   assign out   = out_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic          clk;
   logic          reset;
   execute_data_t ex_v;
   logic          ready;
   dbus_req_t     dreq_s;
   dbus_resp_t    dresp_v;
   memory_data_t  out_s;

   int total = 0;
   int bad   = 0;

   memory_data_t exp_q[$];

   mem_stage dut (
      .clk   (clk),
      .reset (reset),
      .in    (ex_v),
      .ready (ready),
      .dreq  (dreq_s),
      .dresp (dresp_v),
      .out   (out_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Output monitor: sample 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (!reset && out_s.valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'(out_s.valid), 64'h0);
         end else begin
            memory_data_t e;
            e = exp_q.pop_front();
            chk("out_result", out_s.result, e.result);
            chk("out_pc", out_s.pc, e.pc);
            chk("out_ctl", 64'(out_s.ctl), 64'(e.ctl));
            chk("out_addr31", 64'(out_s.addr31), 64'(e.addr31));
         end
      end
   end

   function automatic memory_data_t mk_exp(logic [63:0] pc, control_t c, logic [63:0] res, logic [63:0] alu);
      memory_data_t m;
      m.valid  = 1'b1;
      m.pc     = pc;
      m.ctl    = c;
      m.result = res;
      m.addr31 = alu[31];
      return m;
   endfunction

   task automatic drive_in(input logic [63:0] pc, input logic [1:0] mrw, input logic [4:0] rd,
                           input logic [63:0] alu, input logic [63:0] rs2);
      ex_v.valid      = 1'b1;
      ex_v.pc         = pc;
      ex_v.ctl.RegWEn = 1'b1;
      ex_v.ctl.MemRW  = mrw;
      ex_v.ctl.rd     = rd;
      ex_v.alu        = alu;
      ex_v.rs2        = rs2;
   endtask

   task automatic do_alu(input logic [63:0] pc, input logic [63:0] alu);
      chk("alu_ready_before", 64'(ready), 64'h1);
      drive_in(pc, 2'b00, 5'd3, alu, 64'h0);
      exp_q.push_back(mk_exp(pc, ex_v.ctl, alu, alu));
      @(negedge clk);
      ex_v.valid = 1'b0;
      chk("alu_ready_after", 64'(ready), 64'h1);
      chk("alu_no_dreq", 64'(dreq_s.valid), 64'h0);
   endtask

   task automatic do_mem(input logic is_store, input logic [63:0] pc, input logic [63:0] alu,
                         input logic [63:0] rs2, input int lat, input logic [63:0] rdata);
      control_t c;
      chk("mem_ready_before", 64'(ready), 64'h1);
      drive_in(pc, is_store ? 2'b10 : 2'b01, 5'd7, alu, rs2);
      c = ex_v.ctl;
      @(negedge clk);
      ex_v.valid = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         chk("req_valid", 64'(dreq_s.valid), 64'h1);
         chk("req_addr", dreq_s.addr, alu);
         chk("req_size", 64'(dreq_s.size), 64'(MSIZE8));
         chk("req_strobe", 64'(dreq_s.strobe), is_store ? 64'hFF : 64'h0);
         if (is_store) chk("req_data", dreq_s.data, rs2);
         chk("req_ready_low", 64'(ready), 64'h0);
         if (k == lat) begin
            dresp_v.data_ok = 1'b1;
            dresp_v.data    = rdata;
            exp_q.push_back(mk_exp(pc, c, is_store ? alu : rdata, alu));
         end
         @(negedge clk);
         dresp_v.data_ok = 1'b0;
      end
      chk("done_dreq_low", 64'(dreq_s.valid), 64'h0);
      chk("done_ready", 64'(ready), 64'h1);
   endtask

   initial begin
      ex_v    = '0;
      dresp_v = '0;
      reset   = 1'b1;

      // Reset held two cycles.
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_out_valid", 64'(out_s.valid), 64'h0);
      chk("rst_dreq_valid", 64'(dreq_s.valid), 64'h0);
      chk("rst_ready", 64'(ready), 64'h1);

      // ALU pass-through, including back-to-back.
      do_alu(64'h1000, 64'h5);
      do_alu(64'h1004, 64'hFFFF_FFFF_8000_0000);
      do_alu(64'h1008, 64'h7FFF_FFFF);

      // data_ok arriving while idle must be ignored.
      dresp_v.data_ok = 1'b1;
      dresp_v.data    = 64'hBAD;
      @(negedge clk);
      dresp_v.data_ok = 1'b0;
      chk("idle_dataok_ready", 64'(ready), 64'h1);

      // Loads and stores with varying bus latency.
      do_mem(1'b0, 64'h2000, 64'h8000_0010, 64'h0, 3, 64'hDEAD_BEEF);
      do_mem(1'b1, 64'h2004, 64'h8000_0020, 64'h1234, 2, 64'h0);
      do_mem(1'b0, 64'h2008, 64'h0000_0040, 64'h0, 1, 64'hCAFE_F00D_1234_5678);
      do_alu(64'h200C, 64'h42);
      do_mem(1'b1, 64'h2010, 64'h0000_0048, 64'hA5A5_5A5A_0F0F_F0F0, 1, 64'h0);

      // Reset in the 2nd REQ cycle of a load abandons the access.
      drive_in(64'h3000, 2'b01, 5'd9, 64'h8000_0100, 64'h0);
      @(negedge clk);
      ex_v.valid = 1'b0;
      chk("rreq_valid1", 64'(dreq_s.valid), 64'h1);
      @(negedge clk);
      chk("rreq_valid2", 64'(dreq_s.valid), 64'h1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_dreq_valid", 64'(dreq_s.valid), 64'h0);
      chk("mrst_out_valid", 64'(out_s.valid), 64'h0);
      chk("mrst_ready", 64'(ready), 64'h1);
      do_alu(64'h3004, 64'h99);

`ifdef MEM_MISALIGN_CHECK_EN
      begin
         memory_data_t m;
         drive_in(64'h4000, 2'b01, 5'd11, 64'h8000_0003, 64'h0);
         m = mk_exp(64'h4000, ex_v.ctl, 64'h8000_0003, 64'h8000_0003);
         m.ctl.RegWEn = 1'b0;
         exp_q.push_back(m);
         @(negedge clk);
         ex_v.valid = 1'b0;
         chk("mis_no_dreq", 64'(dreq_s.valid), 64'h0);
         chk("mis_ready", 64'(ready), 64'h1);
         @(negedge clk);
         chk("mis_no_dreq2", 64'(dreq_s.valid), 64'h0);
      end
`endif

      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
